arm_pipelined_mem_arbiter: RTL and testbench
============================================

# arm_pipelined_mem_arbiter

Shares one single-port unified memory between the pipeline's Fetch stage (instruction reads) and Memory stage (loads/stores). Runs a grant FSM with a memory req/ready handshake and returns read data through registered done pulses. Drives stall requests to the hazard unit, which holds Fetch or Memory while its access is outstanding. Sits beside the control unit and hazard unit in the CPU controller.

## Interface
- DATA_W, 32, memory data width
- ADDR_W, 32, memory address width
- MAX_DATA_BURST, 4, consecutive data grants allowed while a fetch waits (used only with the starvation guard)

Ports:
- i_CLK  in  1  single clock, rising edge
- i_NRESET  in  1  asynchronous, active-low reset
- i_Instr_Req  in  1  Fetch requests a read at i_Instr_Addr; held until o_Instr_Done
- i_Instr_Addr  in  ADDR_W  instruction address
- i_Flush_Fetch  in  1  taken branch; cancels the pending or in-flight fetch
- o_Instr_Done  out  1  one-cycle pulse, o_Instr valid
- o_Instr  out  DATA_W  fetched instruction
- i_Data_Req  in  1  Memory stage requests an access; held until o_Data_Done
- i_Data_Write  in  1  1 = store, 0 = load
- i_Data_Addr  in  ADDR_W  data address
- i_Data_WData  in  DATA_W  store data
- o_Data_Done  out  1  one-cycle pulse, access complete
- o_Data_RData  out  DATA_W  load data
- o_Stall_Fetch  out  1  i_Instr_Req & ~o_Instr_Done
- o_Stall_Memory  out  1  i_Data_Req & ~o_Data_Done
- o_Mem_Req  out  1  memory request, held until accepted
- o_Mem_Write  out  1  write strobe
- o_Mem_Addr  out  ADDR_W  memory address
- o_Mem_WData  out  DATA_W  memory write data
- i_Mem_Ready  in  1  memory accepts/completes the access this cycle
- i_Mem_RData  in  DATA_W  read data, valid when i_Mem_Ready = 1

## Operation
- FSM states: IDLE, DATA, INSTR, RESP.
- IDLE: if i_Data_Req, go to DATA. Otherwise, if i_Instr_Req & ~i_Flush_Fetch, go to INSTR. Otherwise stay. Data wins ties because it belongs to the older instruction.
- On grant, latch address, write flag and write data into the o_Mem_* registers. They stay stable until the access completes.
- DATA/INSTR: o_Mem_Req = 1. On i_Mem_Ready, capture i_Mem_RData into o_Data_RData or o_Instr, then go to RESP.
- RESP: pulse the done output for the granted requester for exactly one cycle. No new grant in this state. Then go to IDLE.
- Flush: if i_Flush_Fetch is high during INSTR, or during RESP for a fetch, set a kill flag. The memory access still completes, but o_Instr_Done is suppressed and o_Instr is not updated. The kill flag clears on leaving RESP.
- A store captures nothing: o_Data_RData holds its previous value.
- o_Stall_* are combinational. All other outputs are registered.

## Timing
- Reset values: state IDLE; o_Mem_Req, o_Mem_Write, o_Instr_Done, o_Data_Done = 0; o_Mem_Addr, o_Mem_WData, o_Instr, o_Data_RData = 0; starvation counter 0.
- Reset asserted mid-access drops o_Mem_Req immediately. The access is abandoned and no done pulse is produced.
- Latency: request seen at edge N gives o_Mem_Req from N+1. Ready at cycle N+1+k gives done during cycle N+2+k. With a zero-wait memory, one access takes 3 cycles.
- The requester lowers its request in the cycle after the done pulse. The RESP state prevents a re-grant during the done cycle.
- Ready outside DATA/INSTR is ignored.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined: a counter increments on each data grant made while i_Instr_Req is high. When it reaches MAX_DATA_BURST, the next IDLE grant goes to a waiting fetch even if i_Data_Req is high. The counter clears on any instruction grant, and in any IDLE cycle with i_Instr_Req low.
- Not defined: strict data priority; no counter logic.

## Structure
- Package arm_pipelined_mem_arb_pkg holds the state enum, the DATA_W/ADDR_W defaults and the MAX_DATA_BURST default.
- Sub-module arm_pipelined_mem_arb_starve_ctr holds the guard counter. It is instantiated only under MEM_ARB_STARVE_GUARD_EN.

## Test plan
- Lone fetch, addr 0x100, ready same cycle, rdata 0xE3A01005 -> o_Mem_Req on cycle 1, o_Instr_Done on cycle 2 with o_Instr = 0xE3A01005, o_Stall_Fetch high on cycles 0–1.
- Simultaneous fetch 0x104 and load 0x2000 -> data served first, o_Data_Done; fetch granted next, o_Instr_Done 3 cycles later.
- Store 0x2004 with data 0xDEADBEEF, 3 wait cycles -> o_Mem_Write = 1 and o_Mem_WData = 0xDEADBEEF stable for 4 cycles, o_Data_Done one cycle after ready.
- Flush mid-fetch -> memory access completes, no o_Instr_Done pulse, o_Instr unchanged.
- Reset pulse during DATA with ready low -> o_Mem_Req = 0 immediately, state IDLE, no done pulse.
- With MEM_ARB_STARVE_GUARD_EN, continuous load requests plus a waiting fetch -> fetch granted after exactly 4 data grants; without the macro, fetch waits until i_Data_Req drops.

Source files
------------

// File: rtl/arm_pipelined_mem_arb_pkg.sv
// Shared types and default sizes for the Fetch/Memory single-port memory arbiter.
// No logic; imported by the arbiter top and its starvation-guard counter.
package arm_pipelined_mem_arb_pkg;

  localparam int DATA_W_DEF         = 32;
  localparam int ADDR_W_DEF         = 32;
  localparam int MAX_DATA_BURST_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_INSTR = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  // Counter width able to hold 0..max inclusive.
  function automatic int ctr_width(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/arm_pipelined_mem_arb_starve_ctr.sv
// Counts data grants made while a fetch is waiting; flags when the burst limit is reached.
// Registered count, combinational limit flag; cleared by a fetch grant or an idle cycle with no fetch pending.
module arm_pipelined_mem_arb_starve_ctr
  import arm_pipelined_mem_arb_pkg::*;
#(
  parameter int MAX_DATA_BURST = MAX_DATA_BURST_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic data_grant,
  input  logic instr_grant,
  input  logic instr_waiting,
  input  logic idle_clear,
  output logic starve
);

  localparam int CW = ctr_width(MAX_DATA_BURST);
  localparam logic [CW-1:0] LIMIT = CW'(MAX_DATA_BURST);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (instr_grant || idle_clear) begin
      count <= '0;
    end else if (data_grant && instr_waiting && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign starve = (count == LIMIT);

endmodule

// File: rtl/arm_pipelined_mem_arbiter.sv
// Shares one single-port memory between Fetch and Memory: grant FSM, req/ready handshake, registered done pulses.
// Zero-wait access takes 3 cycles; requesters stall until done. Optional fetch starvation guard: MEM_ARB_STARVE_GUARD_EN.
module arm_pipelined_mem_arbiter
  import arm_pipelined_mem_arb_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int MAX_DATA_BURST = MAX_DATA_BURST_DEF
) (
  input  logic              i_CLK,
  input  logic              i_NRESET,
  input  logic              i_Instr_Req,
  input  logic [ADDR_W-1:0] i_Instr_Addr,
  input  logic              i_Flush_Fetch,
  output logic              o_Instr_Done,
  output logic [DATA_W-1:0] o_Instr,
  input  logic              i_Data_Req,
  input  logic              i_Data_Write,
  input  logic [ADDR_W-1:0] i_Data_Addr,
  input  logic [DATA_W-1:0] i_Data_WData,
  output logic              o_Data_Done,
  output logic [DATA_W-1:0] o_Data_RData,
  output logic              o_Stall_Fetch,
  output logic              o_Stall_Memory,
  output logic              o_Mem_Req,
  output logic              o_Mem_Write,
  output logic [ADDR_W-1:0] o_Mem_Addr,
  output logic [DATA_W-1:0] o_Mem_WData,
  input  logic              i_Mem_Ready,
  input  logic [DATA_W-1:0] i_Mem_RData
);

  arb_state_t state;
  logic       kill;
  logic       fetch_ok;
  logic       pick_data;
  logic       pick_instr;
  logic       starve;

  // Data normally wins: it belongs to the older instruction in the pipe.
  assign fetch_ok   = i_Instr_Req & ~i_Flush_Fetch;
  assign pick_data  = i_Data_Req & ~(starve & fetch_ok);
  assign pick_instr = fetch_ok & ~pick_data;

  assign o_Stall_Fetch  = i_Instr_Req & ~o_Instr_Done;
  assign o_Stall_Memory = i_Data_Req & ~o_Data_Done;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic in_idle;
  assign in_idle = (state == ST_IDLE);

  arm_pipelined_mem_arb_starve_ctr #(
    .MAX_DATA_BURST(MAX_DATA_BURST)
  ) u_starve_ctr (
    .clk          (i_CLK),
    .rst_n        (i_NRESET),
    .data_grant   (in_idle & pick_data),
    .instr_grant  (in_idle & pick_instr),
    .instr_waiting(i_Instr_Req),
    .idle_clear   (in_idle & ~i_Instr_Req),
    .starve       (starve)
  );
`else
  // Strict data priority: the burst limit can never trip.
  assign starve = (MAX_DATA_BURST < 0);
`endif

  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) begin
      state        <= ST_IDLE;
      kill         <= 1'b0;
      o_Mem_Req    <= 1'b0;
      o_Mem_Write  <= 1'b0;
      o_Mem_Addr   <= '0;
      o_Mem_WData  <= '0;
      o_Instr_Done <= 1'b0;
      o_Data_Done  <= 1'b0;
      o_Instr      <= '0;
      o_Data_RData <= '0;
    end else begin
      o_Instr_Done <= 1'b0;
      o_Data_Done  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          kill <= 1'b0;
          if (pick_data) begin
            state       <= ST_DATA;
            o_Mem_Req   <= 1'b1;
            o_Mem_Write <= i_Data_Write;
            o_Mem_Addr  <= i_Data_Addr;
            o_Mem_WData <= i_Data_WData;
          end else if (pick_instr) begin
            state       <= ST_INSTR;
            o_Mem_Req   <= 1'b1;
            o_Mem_Write <= 1'b0;
            o_Mem_Addr  <= i_Instr_Addr;
          end
        end
        ST_DATA: begin
          if (i_Mem_Ready) begin
            state       <= ST_RESP;
            o_Mem_Req   <= 1'b0;
            o_Mem_Write <= 1'b0;
            o_Data_Done <= 1'b1;
            if (!o_Mem_Write) begin
              o_Data_RData <= i_Mem_RData;
            end
          end
        end
        ST_INSTR: begin
          if (i_Flush_Fetch) begin
            kill <= 1'b1;
          end
          // A flush on the completing cycle still counts as a kill.
          if (i_Mem_Ready) begin
            state     <= ST_RESP;
            o_Mem_Req <= 1'b0;
            if (!(kill || i_Flush_Fetch)) begin
              o_Instr_Done <= 1'b1;
              o_Instr      <= i_Mem_RData;
            end
          end
        end
        ST_RESP: begin
          // The done pulse is already on the wire here; the kill flag only lives until we leave.
          state <= ST_IDLE;
          kill  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arm_pipelined_mem_arbiter.sv
// Bench for arm_pipelined_mem_arbiter: directed fetch/load/store/flush/reset/starvation scenarios.
// A transaction-level reference model is compared against the DUT every cycle, plus literal checkpoints.
module tb_arm_pipelined_mem_arbiter;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam int BURST = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_Instr_Req = 1'b0;
  logic [31:0] i_Instr_Addr = '0;
  logic        i_Flush_Fetch = 1'b0;
  logic        o_Instr_Done;
  logic [31:0] o_Instr;
  logic        i_Data_Req = 1'b0;
  logic        i_Data_Write = 1'b0;
  logic [31:0] i_Data_Addr = '0;
  logic [31:0] i_Data_WData = '0;
  logic        o_Data_Done;
  logic [31:0] o_Data_RData;
  logic        o_Stall_Fetch;
  logic        o_Stall_Memory;
  logic        o_Mem_Req;
  logic        o_Mem_Write;
  logic [31:0] o_Mem_Addr;
  logic [31:0] o_Mem_WData;
  logic        i_Mem_Ready = 1'b0;
  logic [31:0] i_Mem_RData = '0;

  arm_pipelined_mem_arbiter #(
    .DATA_W(32), .ADDR_W(32), .MAX_DATA_BURST(BURST)
  ) dut (
    .i_CLK(clk), .i_NRESET(rst_n),
    .i_Instr_Req(i_Instr_Req), .i_Instr_Addr(i_Instr_Addr), .i_Flush_Fetch(i_Flush_Fetch),
    .o_Instr_Done(o_Instr_Done), .o_Instr(o_Instr),
    .i_Data_Req(i_Data_Req), .i_Data_Write(i_Data_Write), .i_Data_Addr(i_Data_Addr),
    .i_Data_WData(i_Data_WData), .o_Data_Done(o_Data_Done), .o_Data_RData(o_Data_RData),
    .o_Stall_Fetch(o_Stall_Fetch), .o_Stall_Memory(o_Stall_Memory),
    .o_Mem_Req(o_Mem_Req), .o_Mem_Write(o_Mem_Write), .o_Mem_Addr(o_Mem_Addr),
    .o_Mem_WData(o_Mem_WData), .i_Mem_Ready(i_Mem_Ready), .i_Mem_RData(i_Mem_RData)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hE3A0_1005;
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory: answers mem_wait cycles after a request appears; force_rdy drives ready with no request.
  int mem_wait = 0;
  int wcnt = 0;
  bit force_rdy = 1'b0;
  always begin
    @(posedge clk);
    #1;
    if (force_rdy) begin
      i_Mem_Ready = 1'b1;
      i_Mem_RData = 32'hBAD0_0000;
    end else if (o_Mem_Req) begin
      if (wcnt >= mem_wait) begin
        i_Mem_Ready = 1'b1;
        i_Mem_RData = mem_rd(o_Mem_Addr);
        wcnt = 0;
      end else begin
        i_Mem_Ready = 1'b0;
        wcnt++;
      end
    end else begin
      i_Mem_Ready = 1'b0;
      wcnt = 0;
    end
  end

  // Reference model: an access is either free, in progress with one owner, or reporting.
  typedef enum int { FREE, BUSY, REPORT } phase_t;
  phase_t      m_phase = FREE;
  bit          m_owner_data = 1'b0;
  bit          m_cancelled = 1'b0;
  int          m_data_streak = 0;
  logic        e_req = 1'b0, e_wr = 1'b0, e_id = 1'b0, e_dd = 1'b0;
  logic [31:0] e_addr = '0, e_wd = '0, e_instr = '0, e_rdata = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = FREE; m_cancelled = 1'b0; m_data_streak = 0;
      e_req = 1'b0; e_wr = 1'b0; e_id = 1'b0; e_dd = 1'b0;
      e_addr = '0; e_wd = '0; e_instr = '0; e_rdata = '0;
    end else begin
      bit fetch_wants;
      bit data_first;
      e_id = 1'b0;
      e_dd = 1'b0;
      fetch_wants = i_Instr_Req && !i_Flush_Fetch;
      if (m_phase == FREE) begin
        data_first = i_Data_Req && !(GUARD && fetch_wants && m_data_streak >= BURST);
        if (data_first) begin
          m_data_streak = i_Instr_Req ? m_data_streak + 1 : 0;
          m_phase = BUSY; m_owner_data = 1'b1;
          e_req = 1'b1; e_wr = i_Data_Write; e_addr = i_Data_Addr; e_wd = i_Data_WData;
        end else if (fetch_wants) begin
          m_data_streak = 0;
          m_phase = BUSY; m_owner_data = 1'b0;
          e_req = 1'b1; e_wr = 1'b0; e_addr = i_Instr_Addr;
        end else if (!i_Instr_Req) begin
          m_data_streak = 0;
        end
      end else if (m_phase == BUSY) begin
        if (!m_owner_data && i_Flush_Fetch) m_cancelled = 1'b1;
        if (i_Mem_Ready) begin
          m_phase = REPORT;
          e_req = 1'b0;
          if (m_owner_data) begin
            e_dd = 1'b1;
            if (!e_wr) e_rdata = i_Mem_RData;
          end else if (!m_cancelled) begin
            e_id = 1'b1;
            e_instr = i_Mem_RData;
          end
        end
      end else begin
        m_phase = FREE;
        m_cancelled = 1'b0;
      end
    end
  end

  // Per-cycle compare and requester bookkeeping.
  int  cyc = 0;
  bit  idone_last = 1'b0, ddone_last = 1'b0;
  int  n_id = 0, n_dd = 0, n_acc = 0;
  int  first_i = -1, first_d = -1, dd_at_first_i = 0;
  always @(negedge clk) begin
    chk("mem_req", 32'(o_Mem_Req), 32'(e_req));
    if (e_req) begin
      chk("mem_addr", o_Mem_Addr, e_addr);
      chk("mem_write", 32'(o_Mem_Write), 32'(e_wr));
      if (e_wr) chk("mem_wdata", o_Mem_WData, e_wd);
    end
    chk("instr_done", 32'(o_Instr_Done), 32'(e_id));
    chk("data_done", 32'(o_Data_Done), 32'(e_dd));
    chk("instr", o_Instr, e_instr);
    chk("data_rdata", o_Data_RData, e_rdata);
    chk("stall_fetch", 32'(o_Stall_Fetch), 32'(i_Instr_Req & ~e_id));
    chk("stall_memory", 32'(o_Stall_Memory), 32'(i_Data_Req & ~e_dd));
    idone_last = o_Instr_Done;
    ddone_last = o_Data_Done;
    if (o_Mem_Req && i_Mem_Ready) n_acc++;
    if (o_Data_Done) begin
      n_dd++;
      if (first_d < 0) first_d = cyc;
    end
    if (o_Instr_Done) begin
      n_id++;
      if (first_i < 0) begin
        first_i = cyc;
        dd_at_first_i = n_dd;
      end
    end
  end

  bit data_hold = 1'b0;

  // Advance one cycle; requesters lower their request the cycle after their done pulse.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (idone_last) i_Instr_Req = 1'b0;
    if (ddone_last) begin
      if (data_hold) i_Data_Addr = i_Data_Addr + 32'd4;
      else i_Data_Req = 1'b0;
    end
  endtask

  initial begin
    int snap_dd, snap_id, snap_acc;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst mem_req", 32'(o_Mem_Req), 32'd0);
    chk("rst mem_write", 32'(o_Mem_Write), 32'd0);
    chk("rst mem_addr", o_Mem_Addr, 32'd0);
    chk("rst instr", o_Instr, 32'd0);
    chk("rst data_rdata", o_Data_RData, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(); tick();

    // Lone fetch, zero-wait memory.
    mem_wait = 0;
    i_Instr_Req = 1'b1; i_Instr_Addr = 32'h100; cyc = 0;
    @(negedge clk);
    chk("t1 c0 stall_fetch", 32'(o_Stall_Fetch), 32'd1);
    chk("t1 c0 mem_req", 32'(o_Mem_Req), 32'd0);
    tick(); @(negedge clk);
    chk("t1 c1 mem_req", 32'(o_Mem_Req), 32'd1);
    chk("t1 c1 mem_addr", o_Mem_Addr, 32'h100);
    chk("t1 c1 stall_fetch", 32'(o_Stall_Fetch), 32'd1);
    tick(); @(negedge clk);
    chk("t1 c2 instr_done", 32'(o_Instr_Done), 32'd1);
    chk("t1 c2 instr", o_Instr, 32'hE3A0_1005);
    chk("t1 c2 stall_fetch", 32'(o_Stall_Fetch), 32'd0);
    tick(); tick();

    // Simultaneous fetch and load: data first, fetch done three cycles later.
    first_i = -1; first_d = -1;
    i_Instr_Req = 1'b1; i_Instr_Addr = 32'h104;
    i_Data_Req = 1'b1; i_Data_Write = 1'b0; i_Data_Addr = 32'h2000; cyc = 0;
    for (int i = 0; i < 20 && first_i < 0; i++) tick();
    chk("t2 data_done cycle", 32'(first_d), 32'd2);
    chk("t2 instr_done cycle", 32'(first_i), 32'd5);
    chk("t2 data_rdata", o_Data_RData, 32'h5A5A_2000);
    chk("t2 instr", o_Instr, 32'h5A5A_0104);
    tick();

    // Store with three wait cycles.
    first_d = -1; mem_wait = 3;
    i_Data_Req = 1'b1; i_Data_Write = 1'b1; i_Data_Addr = 32'h2004; i_Data_WData = 32'hDEAD_BEEF; cyc = 0;
    for (int k = 1; k <= 4; k++) begin
      tick(); @(negedge clk);
      chk("t3 mem_write", 32'(o_Mem_Write), 32'd1);
      chk("t3 mem_wdata", o_Mem_WData, 32'hDEAD_BEEF);
    end
    for (int i = 0; i < 20 && first_d < 0; i++) tick();
    chk("t3 data_done cycle", 32'(first_d), 32'd5);
    chk("t3 rdata kept", o_Data_RData, 32'h5A5A_2000);
    i_Data_Write = 1'b0;
    tick();

    // Flush in the middle of a fetch.
    first_i = -1; mem_wait = 2; snap_acc = n_acc;
    i_Instr_Req = 1'b1; i_Instr_Addr = 32'h108; cyc = 0;
    tick(); tick();
    i_Flush_Fetch = 1'b1; i_Instr_Req = 1'b0;
    tick();
    i_Flush_Fetch = 1'b0;
    repeat (5) tick();
    chk("t4 no instr_done", 32'(first_i), 32'hFFFF_FFFF);
    chk("t4 access completed", 32'(n_acc - snap_acc), 32'd1);
    chk("t4 instr kept", o_Instr, 32'h5A5A_0104);

    // Reset pulse while a load waits on the memory.
    mem_wait = 5; snap_dd = n_dd;
    i_Data_Req = 1'b1; i_Data_Write = 1'b0; i_Data_Addr = 32'h3000; cyc = 0;
    tick(); tick();
    #2;
    rst_n = 1'b0; i_Data_Req = 1'b0;
    #1;
    chk("t5 mem_req dropped", 32'(o_Mem_Req), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) tick();
    chk("t5 no data_done", 32'(n_dd - snap_dd), 32'd0);
    chk("t5 rdata reset", o_Data_RData, 32'd0);

    // Ready with nobody granted is ignored.
    snap_dd = n_dd; snap_id = n_id;
    force_rdy = 1'b1;
    repeat (3) tick();
    force_rdy = 1'b0;
    tick();
    chk("t6 stray ready dones", 32'((n_dd - snap_dd) + (n_id - snap_id)), 32'd0);
    chk("t6 stray ready rdata", o_Data_RData, 32'd0);

    // Back-to-back loads against a waiting fetch.
    mem_wait = 0; first_i = -1; snap_dd = n_dd; data_hold = 1'b1;
    i_Data_Req = 1'b1; i_Data_Write = 1'b0; i_Data_Addr = 32'h4000;
    i_Instr_Req = 1'b1; i_Instr_Addr = 32'h200; cyc = 0;
    for (int i = 0; i < 80 && first_i < 0; i++) begin
      tick();
      if (!GUARD && (n_dd - snap_dd) >= 5) data_hold = 1'b0;
    end
    chk("t7 data grants before fetch", 32'(dd_at_first_i - snap_dd), GUARD ? 32'd4 : 32'd6);
    chk("t7 fetched instr", o_Instr, 32'h5A5A_0200);
    data_hold = 1'b0;
    for (int i = 0; i < 20 && (i_Data_Req || i_Instr_Req); i++) tick();
    chk("t7 requests retired", 32'({i_Data_Req, i_Instr_Req}), 32'd0);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
